// File: rtl/menu_pixel_gen_pkg.sv
// menu_pixel_gen_pkg: colours, screen-memory codes and line geometry shared by the pixel generators
package menu_pixel_gen_pkg;
  typedef enum logic {BTN_IDLE, BTN_ARMED} btn_state_t;
  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] TOUCH = 12'h32E;
  localparam logic [11:0] CLICK = 12'h3E2;
  localparam int CODE_WHITE = 0;
  localparam int CODE_BLACK = 1;
  localparam int CODE_BTN = 2;
  localparam int LINE_STRIDE = 640;
  function automatic logic in_rect(input logic [39:0] rect, input logic [9:0] x, input logic [9:0] y);
    return x >= rect[39:30] && x <= rect[19:10] && y >= rect[29:20] && y <= rect[9:0];
  endfunction
endpackage

// File: rtl/menu_pixel_gen_btn_fsm.sv
// menu_btn_fsm: arms on a press inside the button, pulses click on a release still inside
module menu_btn_fsm
  import menu_pixel_gen_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_hit,
  input  logic i_rise,
  input  logic i_fall,
  output logic o_armed,
  output logic o_click
);
  btn_state_t r_state, w_next;
  logic r_click, w_click;
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= BTN_IDLE;
      r_click <= 1'b0;
    end else begin
      r_state <= w_next;
      r_click <= w_click;
    end
  always_comb
    w_next = (r_state == BTN_IDLE) ? ((i_rise && i_hit) ? BTN_ARMED : BTN_IDLE)
                                   : (i_fall ? BTN_IDLE : BTN_ARMED);
  always_comb begin
    o_armed = r_state == BTN_ARMED;
    w_click = o_armed && i_fall && i_hit;
  end
  assign o_click = r_click;
endmodule

// File: rtl/menu_pixel_gen.sv
// menu_pixel_gen: maps screen-memory codes to RGB444 with mouse hover/click feedback on menu buttons
module menu_pixel_gen
  import menu_pixel_gen_pkg::*;
#(
  parameter int N_BTN = 4,
  parameter int CODE_W = 3,
  parameter int MEM_LAT = 1,
  parameter logic [40*N_BTN-1:0] BTN_RECT = {
    10'd500, 10'd400, 10'd599, 10'd449,
    10'd150, 10'd130, 10'd249, 10'd179,
    10'd300, 10'd100, 10'd399, 10'd149,
    10'd100, 10'd100, 10'd199, 10'd149}
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              valid,
  input  logic [9:0]        mouse_x,
  input  logic [9:0]        mouse_y,
  input  logic              mouse_left,
  output logic [18:0]       mem_addr,
  input  logic [CODE_W-1:0] mem_code,
  output logic [11:0]       pixel_out,
  output logic              pixel_valid,
  output logic [N_BTN-1:0]  btn_hover,
  output logic [N_BTN-1:0]  btn_click
);
  logic r_ml, r_blk, r_pv;
  logic [18:0] r_addr;
  logic [MEM_LAT:0] r_vld;
  logic [11:0] r_pix, w_btn_color, w_color;
  logic [N_BTN-1:0] r_hover, r_arm_l, w_hit, w_armed, w_click;
  logic w_rise, w_fall, w_frame;
  // r_blk keeps a press held across reset from ever arming a button
  assign w_rise = mouse_left && !r_ml && !r_blk;
  assign w_fall = !mouse_left && r_ml;
  assign w_frame = h_cnt == 10'd0 && v_cnt == 10'd0;
  always_ff @(posedge clk)
    if (rst) begin
      r_ml <= 1'b0;
      r_blk <= 1'b1;
      r_addr <= '0;
      r_vld <= '0;
      r_pv <= 1'b0;
      r_pix <= BLACK;
      r_hover <= '0;
      r_arm_l <= '0;
    end else begin
      r_ml <= mouse_left;
      r_blk <= r_blk && mouse_left;
      r_addr <= 19'(h_cnt) + 19'(v_cnt) * 19'(LINE_STRIDE);
      r_vld <= {r_vld[MEM_LAT-1:0], valid};
      r_pv <= r_vld[MEM_LAT];
      r_pix <= r_vld[MEM_LAT] ? w_color : BLACK;
      r_hover <= w_frame ? w_hit : r_hover;
      r_arm_l <= w_frame ? w_armed : r_arm_l;
    end
  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    assign w_hit[g] = in_rect(BTN_RECT[40*g +: 40], mouse_x, mouse_y);
    menu_btn_fsm u_fsm (
      .clk     (clk),
      .rst     (rst),
      .i_hit   (w_hit[g]),
      .i_rise  (w_rise),
      .i_fall  (w_fall),
      .o_armed (w_armed[g]),
      .o_click (w_click[g])
    );
  end
  // colouring only sees frame-latched hover/armed so a frame never changes mid-scan
  always_comb begin
    w_btn_color = BLACK;
    for (int k = 0; k < N_BTN; k++)
      if (mem_code == CODE_W'(CODE_BTN + k))
        w_btn_color = r_hover[k] ? (r_arm_l[k] ? CLICK : TOUCH) : BLACK;
    w_color = (mem_code == CODE_W'(CODE_WHITE)) ? WHITE :
              (mem_code == CODE_W'(CODE_BLACK)) ? BLACK : w_btn_color;
  end
  assign mem_addr = r_addr;
  assign pixel_out = r_pix;
  assign pixel_valid = r_pv;
  assign btn_hover = r_hover;
  assign btn_click = w_click;
endmodule

// File: doc/menu_pixel_gen.md
MENU_PIXEL_GEN -- requirements
Module: menu_pixel_gen

Interface
REQ-001 SHALL have parameter N_BTN, default 4, number of clickable buttons (1..6).
REQ-002 SHALL have parameter CODE_W, default 3, width of the screen-memory pixel code; 2^CODE_W >= N_BTN+2.
REQ-003 SHALL have parameter MEM_LAT, default 1, read latency of the external screen memory in clocks (1..3).
REQ-004 SHALL have parameter BTN_RECT, default 4 x {x0,y0,x1,y1} as 10-bit fields, i.e. 40*N_BTN bits, inclusive hit rectangles.
REQ-005 SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-006 Ports SHALL be:
  clk  in  1  pixel clock
  rst  in  1  synchronous active-high reset
  h_cnt  in  10  horizontal pixel counter
  v_cnt  in  10  vertical line counter
  valid  in  1  display-active qualifier for h_cnt/v_cnt
  mouse_x  in  10  mouse column
  mouse_y  in  10  mouse row
  mouse_left  in  1  left button level
  mem_addr  out  19  screen-memory read address
  mem_code  in  CODE_W  screen-memory read data
  pixel_out  out  12  RGB444 pixel
  pixel_valid  out  1  pixel_out qualifier
  btn_hover  out  N_BTN  per-button hover, frame-stable
  btn_click  out  N_BTN  one-cycle click pulse per button

Function
REQ-007 mem_addr SHALL be registered: h_cnt + 640*v_cnt, 19-bit, updated every clock.
REQ-008 The pipeline SHALL have total latency MEM_LAT+2 from h_cnt/v_cnt/valid to pixel_out/pixel_valid: 1 address stage, MEM_LAT memory stages, 1 colour stage; valid SHALL be delayed identically.
REQ-009 Code mapping SHALL be: 0 -> WHITE 12'hFFF; 1 -> BLACK 12'h000; 2+k (k<N_BTN) -> button k colour; any other code -> BLACK.
REQ-010 Button k colour SHALL be CLICK 12'h3E2 if hover_k and button k FSM is ARMED; else TOUCH 12'h32E if hover_k; else BLACK.
REQ-011 pixel_out SHALL be BLACK whenever the delayed valid is 0.
REQ-012 Raw hit_k SHALL be x0<=mouse_x<=x1 and y0<=mouse_y<=y1 (unsigned, inclusive), evaluated every clock.
REQ-013 btn_hover and the ARMED bits used for colouring SHALL be latched only on the cycle h_cnt==0, v_cnt==0 (frame start), so colouring never changes mid-frame.
REQ-014 Each button SHALL run a two-state FSM on raw hit_k and mouse_left, sampled every clock, independent of the frame latch:
  IDLE -> ARMED on mouse_left rising edge with hit_k=1;
  ARMED -> IDLE with btn_click[k]=1 for one cycle on mouse_left falling edge with hit_k=1;
  ARMED -> IDLE with no pulse on mouse_left falling edge with hit_k=0;
  ARMED persists while mouse_left held, including while the pointer leaves and re-enters.
REQ-015 A press beginning outside the rectangle SHALL never arm, even if the pointer then enters.
REQ-016 Edge detection SHALL use a one-cycle registered copy of mouse_left; a rise and a fall SHALL never be detected in the same cycle.
REQ-017 Overlapping rectangles: every hit button SHALL arm independently; no priority.
REQ-018 btn_click SHALL be a registered output, asserted at most one cycle per press/release pair.

Reset
REQ-019 On rst: all FSMs IDLE; mouse_left delay 0; btn_hover 0; btn_click 0; mem_addr 0; pipeline valid bits 0; pixel_out BLACK; pixel_valid 0.
REQ-020 rst asserted while ARMED SHALL drop to IDLE with no click pulse, even if mouse_left falls during or right after reset.
REQ-021 First frame after reset SHALL render with btn_hover=0 until the next frame-start latch.

Structure
REQ-022 Colour constants WHITE/BLACK/TOUCH/CLICK, code values 0/1/2 base, and the 640 line stride SHALL live in a shared package/include used by all pixel generators.
REQ-023 The per-button FSM SHALL be sub-module menu_btn_fsm, instantiated N_BTN times via generate.
REQ-024 The screen memory SHALL stay outside this block.

Verification
REQ-025 MEM_LAT=1, memory model returns code 0 at address 0: h_cnt=0,v_cnt=0,valid=1 -> pixel_out=12'hFFF, pixel_valid=1 exactly 3 clocks later; h_cnt=5,v_cnt=2 -> mem_addr=1285 next clock.
REQ-026 Button0 rect {100,100,199,149}, mouse (150,120), mouse_left=0, frame start passes -> btn_hover[0]=1, code-2 pixels = 12'h32E; mouse (200,120) next frame -> code-2 pixels BLACK.
REQ-027 Mouse (150,120), press then release 10 clocks later -> btn_click[0] high exactly 1 clock, the cycle after the falling edge registers; after the next frame start while held, code-2 pixels = 12'h3E2.
REQ-028 Press at (150,120), move to (300,300), release -> no pulse; press at (300,300), move to (150,120), release -> no pulse.
REQ-029 Press inside, assert rst 2 clocks, release during rst -> no pulse, all outputs at reset values, pixel_valid=0 for MEM_LAT+2 clocks after rst deasserts.
REQ-030 Codes 2+N_BTN..2^CODE_W-1 and valid=0 with code 0 -> pixel_out=12'h000.
